// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced 8-bit datapath and the external ALU:
// opcodes, flag bit positions, instruction field positions and FSM encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // rt and imm overlap on bit 7; imm is only meaningful for LDI
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 7;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// General register file: two combinational read ports, one synchronous
// write port, synchronous clear.
module regfile4x8 #(
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_a,
  output logic [7:0]    rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata
);

  logic [7:0] mem_q [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [7:0] r_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_reg <= 8'h00;
        end else if (we && (waddr == AW'(gi))) begin
          r_reg <= wdata;
        end
      end
      assign mem_q[gi] = r_reg;
    end
  endgenerate

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_seq8.sv
// Three-state sequencer around an external 8-bit ALU: accept, execute,
// then hold a completion record; register/flag writeback on handshake only.
module alu_seq8
  import alu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_err,
  output logic [3:0]  flags
);

  localparam int AW = 2;

  state_t      state_reg;
  logic [15:0] instr_reg;
  logic [7:0]  result_reg;
  logic [3:0]  pflags_reg;
  logic [3:0]  flags_reg;

  logic [2:0]    op;
  logic [AW-1:0] rd, rs, rt;
  logic [7:0]    imm;
  logic [7:0]    rdata_a, rdata_b;
  logic          exec, done, handshake, reg_we;

  assign op  = instr_reg[OP_MSB:OP_LSB];
  assign rd  = instr_reg[RD_MSB:RD_LSB];
  assign rs  = instr_reg[RS_MSB:RS_LSB];
  assign rt  = instr_reg[RT_MSB:RT_LSB];
  assign imm = instr_reg[IMM_MSB:IMM_LSB];

  assign exec      = (state_reg == ST_EXEC);
  assign done      = (state_reg == ST_DONE);
  assign handshake = done && out_ready;
  // Reset takes priority: an aborted record never reaches the register file
  assign reg_we    = handshake && (op != OP_ILL) && !rst;

  regfile4x8 #(.NREG(NREG), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (reg_we),
    .waddr   (rd),
    .wdata   (result_reg)
  );

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign alu_a     = exec ? rdata_a : 8'h00;
  assign alu_b     = exec ? rdata_b : 8'h00;
  assign alu_op    = exec ? op : OP_ADD;
  assign out_valid = done;
  assign out_data  = done ? result_reg : 8'h00;
  assign out_err   = done && (op == OP_ILL);
  assign flags     = flags_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      instr_reg  <= 16'h0000;
      result_reg <= 8'h00;
      pflags_reg <= 4'h0;
      flags_reg  <= 4'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            instr_reg <= in_instr;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op)
            OP_LDI: begin
              result_reg <= imm;
              pflags_reg <= 4'h0;
            end
            OP_ILL: begin
              result_reg <= 8'h00;
              pflags_reg <= 4'h0;
            end
            default: begin
              result_reg <= alu_result;
              pflags_reg <= alu_flags;
            end
          endcase
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            if (is_alu_op(op)) flags_reg <= pflags_reg;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq8.md
ALU_SEQ8 -- requirements
Module: alu_seq8

Interface
REQ-001 Parameter NREG, default 4, meaning number of 8-bit general registers (fixed at 4; index width 2).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 in_instr  input  16  [15:13] op, [12:11] rd, [10:9] rs, [8:7] rt, [7:0] imm (LDI only).
REQ-007 alu_a, alu_b  output  8 each  operands driven to the external 8-bit ALU.
REQ-008 alu_op  output  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT.
REQ-009 alu_result  input  8  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-010 alu_flags  input  4  ALU flags: [0] Z, [1] C, [2] N, [3] V.
REQ-011 out_valid  output  1  completion record available.
REQ-012 out_ready  input  1  consumer accepts the completion record.
REQ-013 out_data  output  8  value written to rd; 0 on error.
REQ-014 out_err  output  1  instruction was illegal.
REQ-015 flags  output  4  architectural flags register, same bit order as alu_flags.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and DONE; transitions: IDLE->EXEC on in_valid&in_ready; EXEC->DONE unconditionally; DONE->IDLE on out_valid&out_ready; otherwise hold.
REQ-017 in_ready SHALL equal (state==IDLE), and SHALL be 0 in any cycle where rst is high.
REQ-018 On acceptance, in_instr SHALL be latched into an instruction register; in_instr is ignored in all other cycles.
REQ-019 In EXEC: alu_a=R[rs], alu_b=R[rt], alu_op=op[2:0] for ops 000-101; alu_result and alu_flags SHALL be captured into a result register and a pending-flags register at the end of EXEC.
REQ-020 Op 110 (LDI): the result register SHALL capture imm; the ALU is not used; flags are not updated.
REQ-021 Op 111: illegal; the result register SHALL capture 0 and out_err SHALL be 1 in DONE; no register write and no flag update.
REQ-022 In DONE: out_valid=1; out_data, out_err SHALL be held stable until out_ready.
REQ-023 Register write R[rd] and the flags update (ALU ops only) SHALL occur on the handshake cycle (out_valid&out_ready), not before.
REQ-024 Minimum latency SHALL be acceptance at cycle 0, EXEC at cycle 1, out_valid at cycle 2; throughput SHALL be one instruction per 3 cycles with out_ready held high.
REQ-025 rd==rs or rd==rt SHALL read the old value; operands are sampled in EXEC, before the write.
REQ-026 Outside EXEC: alu_a=0, alu_b=0, alu_op=000.
REQ-027 out_valid SHALL be 0 in IDLE and EXEC; out_data and out_err SHALL be 0 whenever out_valid is 0.

Reset
REQ-028 When rst is high, state SHALL go to IDLE, R[0..3]=0x00, flags=4'b0000, and the instruction, result and pending-flags registers SHALL be 0.
REQ-029 Reset in EXEC or DONE SHALL abort the instruction with no register write and no flag update; out_valid SHALL be 0 on the next cycle.
REQ-030 The first acceptance SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 Opcode constants (ADD..SLT, LDI, ILL), flag bit indices, instruction field positions and the FSM state encoding SHALL live in a shared package alu_pkg, also used by the ALU.
REQ-032 The register file SHALL be a sub-module regfile4x8: 2 combinational read ports, 1 synchronous write port, synchronous reset to zero.
REQ-033 The external ALU SHALL NOT be instantiated inside alu_seq8; it connects at the level above.

Verification
REQ-034 LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 -> out_data=0x80, flags=4'b1100 (V, N).
REQ-035 SUB r0,r2,r2 with r2=0x01 -> out_data=0x00, flags=4'b0001; R0=0x00.
REQ-036 in_instr op=111 -> out_err=1, out_data=0x00; flags and all registers unchanged.
REQ-037 ADD with out_ready low for 5 cycles -> out_valid stays high with out_data stable, in_ready=0, R[rd] unchanged until the handshake.
REQ-038 rst asserted in DONE of LDI r1,0xAA -> R1 keeps its old value, state IDLE, in_ready=1 in the cycle after rst deasserts.
REQ-039 Back-to-back LDI r0,0x05 then ADD r0,r0,r0 with out_ready high -> second out_data=0x0A, out_valid at cycles 2 and 5.
